// File: rtl/spi_display_receiver_pkg.sv
// Shared definitions for the MAX7219-style display receiver: register addresses,
// FSM state encoding and bit-counter sizing.
package spi_display_receiver_pkg;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    localparam int unsigned DIGIT_BITS = 8;
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        LATCH     = 2'd3
    } state_t;

endpackage

// File: rtl/spi_display_receiver_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input followed by an edge-detect flop.
module spi_display_receiver_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic res,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (res) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_display_receiver.sv
// SPI slave for 16-bit display command words; decodes them into the display
// register file and reports each accepted or discarded frame with a pulse.
module spi_display_receiver
    import spi_display_receiver_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WORD_BITS   = 16
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   sck,
    input  logic                   mosi,
    input  logic                   cs,
    output logic [63:0]            digit_regs,
    output logic [7:0]             decode_mode,
    output logic [3:0]             intensity,
    output logic [2:0]             scan_limit,
    output logic                   display_on,
    output logic                   display_test,
    output logic [WORD_BITS-1:0]   frame_word,
    output logic                   frame_valid,
    output logic                   frame_error
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);

    logic sck_level, sck_rise, sck_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic cs_level, cs_rise, cs_fall;

    state_t               state;
    logic [WORD_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]     bit_count;
    logic [3:0]           word_addr;
    logic [7:0]           word_data;
    logic [5:0]           digit_base;
    logic                 unused_edges;

    spi_display_receiver_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .res(res), .din(sck),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );

    spi_display_receiver_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .res(res), .din(mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    spi_display_receiver_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .res(res), .din(cs),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    // Only sck rises, mosi level and cs edges/level steer the receiver.
    assign unused_edges = ^{sck_level, sck_fall, mosi_rise, mosi_fall};

    assign word_addr  = shift_reg[11:8];
    assign word_data  = shift_reg[7:0];
    assign digit_base = {3'(word_addr - 4'd1), 3'b000};

    always_ff @(posedge clk) begin
        if (res) begin
            state        <= WAIT_HIGH;
            shift_reg    <= '0;
            bit_count    <= '0;
            digit_regs   <= '0;
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            display_on   <= 1'b0;
            display_test <= 1'b0;
            frame_word   <= '0;
            frame_valid  <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                // A frame already running when reset released is never joined.
                WAIT_HIGH: begin
                    if (cs_level) state <= IDLE;
                end
                IDLE: begin
                    if (cs_fall) begin
                        shift_reg <= '0;
                        bit_count <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        shift_reg <= {shift_reg[WORD_BITS-2:0], mosi_level};
                        if (bit_count != CNT_MAX) bit_count <= bit_count + 1'b1;
                    end
                    if (cs_rise) state <= LATCH;
                end
                LATCH: begin
                    state <= IDLE;
                    // Overlong frames keep the newest word (daisy-chain pass-through).
                    if (bit_count >= CNT_FULL) begin
                        frame_word  <= shift_reg;
                        frame_valid <= 1'b1;
                        case (word_addr)
                            ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
                            ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                                digit_regs[digit_base +: DIGIT_BITS] <= word_data;
                            ADDR_DECODE:    decode_mode  <= word_data;
                            ADDR_INTENSITY: intensity    <= word_data[3:0];
                            ADDR_SCANLIM:   scan_limit   <= word_data[2:0];
                            ADDR_SHUTDOWN:  display_on   <= word_data[0];
                            ADDR_TEST:      display_test <= word_data[0];
                            default: ;
                        endcase
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
                default: state <= WAIT_HIGH;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_display_receiver.sv
// Directed bench for spi_display_receiver: drives SPI frames at 4 clk per bit
// and checks the register file, frame word, pulse counts and latency.
module tb_spi_display_receiver;

    logic        clk = 1'b0;
    logic        res;
    logic        sck;
    logic        mosi;
    logic        cs;
    logic [63:0] digit_regs;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        display_on;
    logic        display_test;
    logic [15:0] frame_word;
    logic        frame_valid;
    logic        frame_error;

    int checks = 0;
    int errors = 0;
    int nvalid = 0;
    int nerror = 0;
    int lat;
    int v0, e0;

    spi_display_receiver #(.SYNC_STAGES(2), .WORD_BITS(16)) dut (
        .clk(clk), .res(res), .sck(sck), .mosi(mosi), .cs(cs),
        .digit_regs(digit_regs), .decode_mode(decode_mode), .intensity(intensity),
        .scan_limit(scan_limit), .display_on(display_on), .display_test(display_test),
        .frame_word(frame_word), .frame_valid(frame_valid), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_valid) nvalid <= nvalid + 1;
        if (frame_error) nerror <= nerror + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
        wait_clk(2);
    endtask

    task automatic shift_bits(input int nbits, input logic [31:0] val);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = val[i];
            sck  = 1'b0;
            wait_clk(2);
            sck  = 1'b1;
            wait_clk(2);
        end
        sck = 1'b0;
        wait_clk(2);
    endtask

    // Raise cs and report how many clocks until a frame pulse appears (-1 if none).
    task automatic cs_high(output int latency);
        cs = 1'b1;
        latency = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (latency < 0 && (frame_valid || frame_error)) latency = i;
        end
    endtask

    task automatic send(input int nbits, input logic [31:0] val, output int latency);
        cs_low();
        shift_bits(nbits, val);
        cs_high(latency);
    endtask

    initial begin
        res = 1'b1; sck = 1'b0; mosi = 1'b0; cs = 1'b1;
        wait_clk(3);
        res = 1'b0;
        @(negedge clk);
        check("rst_digits", digit_regs, 64'h0);
        check("rst_decode", 64'(decode_mode), 64'h0);
        check("rst_intensity", 64'(intensity), 64'h0);
        check("rst_scan", 64'(scan_limit), 64'h0);
        check("rst_display_on", 64'(display_on), 64'h0);
        check("rst_test", 64'(display_test), 64'h0);
        check("rst_word", 64'(frame_word), 64'h0);
        check("rst_pulses", 64'({frame_valid, frame_error}), 64'h0);
        wait_clk(5);

        // Shutdown off, then decode-mode all digits
        send(16, 32'h0C01, lat);
        check("latency_valid", 64'(lat), 64'd4);
        send(16, 32'h09FF, lat);
        check("display_on", 64'(display_on), 64'h1);
        check("decode_mode", 64'(decode_mode), 64'hFF);
        check("valid_count2", 64'(nvalid), 64'd2);
        check("word_09ff", 64'(frame_word), 64'h09FF);
        check("no_errors", 64'(nerror), 64'd0);

        send(16, 32'h0105, lat);
        send(16, 32'h0287, lat);
        send(16, 32'h0603, lat);
        check("digits_136", digit_regs, 64'h0000_0300_0000_8705);
        check("word_0603", 64'(frame_word), 64'h0603);

        // Short frame is discarded
        v0 = nvalid; e0 = nerror;
        send(12, 32'h0A5, lat);
        check("latency_error", 64'(lat), 64'd4);
        check("short_err_pulse", 64'(nerror - e0), 64'd1);
        check("short_no_valid", 64'(nvalid - v0), 64'd0);
        check("short_intensity", 64'(intensity), 64'h0);
        check("short_word", 64'(frame_word), 64'h0603);

        // Overlong frame keeps the newest 16 bits
        v0 = nvalid;
        send(24, 32'hAB0307, lat);
        check("long_word", 64'(frame_word), 64'h0307);
        check("long_digits", digit_regs, 64'h0000_0300_0007_8705);
        check("long_valid", 64'(nvalid - v0), 64'd1);

        // sck activity with cs high must be ignored
        v0 = nvalid; e0 = nerror;
        for (int i = 0; i < 20; i++) begin
            sck = 1'b1; mosi = i[0];
            wait_clk(2);
            sck = 1'b0;
            wait_clk(2);
        end
        wait_clk(6);
        check("toggle_no_valid", 64'(nvalid - v0), 64'd0);
        check("toggle_no_error", 64'(nerror - e0), 64'd0);
        send(16, 32'h0A0F, lat);
        check("intensity_f", 64'(intensity), 64'hF);
        check("toggle_digits", digit_regs, 64'h0000_0300_0007_8705);
        check("toggle_decode", 64'(decode_mode), 64'hFF);
        check("toggle_valid", 64'(nvalid - v0), 64'd1);

        // Remaining registers, plus don't-care upper nibble and unmapped addresses
        send(16, 32'hFB07, lat);
        check("scan_limit", 64'(scan_limit), 64'h7);
        send(16, 32'h0F01, lat);
        check("display_test", 64'(display_test), 64'h1);
        v0 = nvalid;
        send(16, 32'h0D55, lat);
        send(16, 32'h0000, lat);
        check("noop_valid", 64'(nvalid - v0), 64'd2);
        check("noop_digits", digit_regs, 64'h0000_0300_0007_8705);
        check("noop_intensity", 64'(intensity), 64'hF);
        send(16, 32'h0C00, lat);
        check("shutdown", 64'(display_on), 64'h0);

        // Reset in the middle of a frame
        cs_low();
        shift_bits(8, 32'h0C);
        res = 1'b1;
        wait_clk(2);
        res = 1'b0;
        v0 = nvalid; e0 = nerror;
        shift_bits(8, 32'h01);
        cs_high(lat);
        check("midrst_no_pulse", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
        check("midrst_valid", 64'(nvalid - v0), 64'd0);
        check("midrst_error", 64'(nerror - e0), 64'd0);
        check("midrst_display", 64'(display_on), 64'h0);
        check("midrst_digits", digit_regs, 64'h0);
        check("midrst_intensity", 64'(intensity), 64'h0);
        send(16, 32'h0C01, lat);
        check("after_rst_on", 64'(display_on), 64'h1);
        check("after_rst_word", 64'(frame_word), 64'h0C01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
